// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants, geometry type and sync/visible-window decode
// used by the timing generator and by the sprite/background controllers.
package vga_timing_pkg;

  localparam int COUNT_W         = 10;
  localparam int CLK_DIV_DEFAULT = 4;

  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_VIS_START = 144;
  localparam int H_VIS_END   = 784;

  localparam int V_TOTAL     = 525;
  localparam int V_SYNC      = 2;
  localparam int V_VIS_START = 35;
  localparam int V_VIS_END   = 515;

  localparam int SCREEN_W = H_VIS_END - H_VIS_START;
  localparam int SCREEN_H = V_VIS_END - V_VIS_START;

  typedef logic [COUNT_W-1:0] count_t;

  typedef struct packed {
    int h_total;
    int h_sync;
    int h_vis_start;
    int h_vis_end;
    int v_total;
    int v_sync;
    int v_vis_start;
    int v_vis_end;
  } vga_geom_t;

  localparam vga_geom_t VGA_640X480 = '{
    h_total:     H_TOTAL,
    h_sync:      H_SYNC,
    h_vis_start: H_VIS_START,
    h_vis_end:   H_VIS_END,
    v_total:     V_TOTAL,
    v_sync:      V_SYNC,
    v_vis_start: V_VIS_START,
    v_vis_end:   V_VIS_END
  };

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic bright;
  } sync_t;

  function automatic logic in_span(input count_t x, input count_t lo, input count_t hi);
    return (x >= lo) && (x < hi);
  endfunction

  // Sync pulses sit at the start of each line/frame, so both are low at (0,0).
  function automatic sync_t decode_sync(input count_t h, input count_t v, input vga_geom_t g);
    sync_t s;
    s.hsync  = (h >= count_t'(g.h_sync));
    s.vsync  = (v >= count_t'(g.v_sync));
    s.bright = in_span(h, count_t'(g.h_vis_start), count_t'(g.h_vis_end)) &&
               in_span(v, count_t'(g.v_vis_start), count_t'(g.v_vis_end));
    return s;
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: registered pix_en high for one clk out of every CLK_DIV,
// first asserted CLK_DIV-1 edges after reset release.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
    pix_en_d = (div_d == DIV_LAST);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: hCount/vCount/bright bus, hSync/vSync, pixel and
// end-of-frame ticks. Define VGA_SYNC_ALIGN_EN to delay hSync/vSync by one clk.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int        CLK_DIV = CLK_DIV_DEFAULT,
  parameter vga_geom_t GEOM    = VGA_640X480
) (
  input  logic               ClkPort,
  input  logic               rst,
  output logic               pix_en,
  output logic [COUNT_W-1:0] hCount,
  output logic [COUNT_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               frame_tick
);

  localparam count_t H_LAST = count_t'(GEOM.h_total - 1);
  localparam count_t V_LAST = count_t'(GEOM.v_total - 1);
  localparam count_t ONE    = count_t'(1);

  logic   pix_en_w;
  count_t h_q, h_d;
  count_t v_q, v_d;
  sync_t  sync_q, sync_d;
  logic   line_end, frame_end;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk    (ClkPort),
    .rst    (rst),
    .pix_en (pix_en_w)
  );

  // Sync/bright decode the next position so they switch on the same edge as
  // the counters instead of one pixel late.
  always_comb begin
    // NOTE: every signal gets a default before the conditionals so no path
    // leaves it unassigned, which would infer a latch.
    h_d       = h_q;
    v_d       = v_q;
    line_end  = (h_q == H_LAST);
    frame_end = line_end && (v_q == V_LAST);
    if (pix_en_w) begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
      end else begin
        h_d = h_q + ONE;
      end
    end
    sync_d = decode_sync(h_d, v_d, GEOM);
  end

  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      sync_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      sync_q <= sync_d;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  // Extra stage matches the sprite controllers' ROM read latency at the DAC.
  logic hsync_dly_q, hsync_dly_d;
  logic vsync_dly_q, vsync_dly_d;

  always_comb begin
    hsync_dly_d = sync_q.hsync;
    vsync_dly_d = sync_q.vsync;
  end

  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      hsync_dly_q <= 1'b0;
      vsync_dly_q <= 1'b0;
    end else begin
      hsync_dly_q <= hsync_dly_d;
      vsync_dly_q <= vsync_dly_d;
    end
  end

  assign hSync = hsync_dly_q;
  assign vSync = vsync_dly_q;
`else
  assign hSync = sync_q.hsync;
  assign vSync = sync_q.vsync;
`endif

  assign pix_en     = pix_en_w;
  assign hCount     = h_q;
  assign vCount     = v_q;
  assign bright     = sync_q.bright;
  assign frame_tick = pix_en_w & frame_end;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
- Produces the hCount/vCount/bright bus consumed by every sprite/background controller (seats, player sprites) and the hSync/vSync pins.
- Sits directly upstream of the sprite controllers; their rgb output goes to the VGA DAC.
- Also emits a pixel tick and an end-of-frame tick for game logic.

Parameters:
- CLK_DIV, 4: clk cycles per pixel (100 MHz / 4 = 25 MHz); legal 1..16.
- H_TOTAL, 800: pixels per line.
- H_SYNC, 96: hSync low width, starts at hCount 0.
- H_VIS_START, 144: first visible hCount.
- H_VIS_END, 784: first non-visible hCount after the visible span.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 2: vSync low width, starts at vCount 0.
- V_VIS_START, 35: first visible vCount.
- V_VIS_END, 515: first non-visible vCount after the visible span.

Ports:
- ClkPort  in  1  100 MHz system clock.
- rst  in  1  asynchronous active-high reset.
- pix_en  out  1  one-clk pulse per pixel period.
- hCount  out  10  horizontal position, 0..H_TOTAL-1.
- vCount  out  10  vertical position, 0..V_TOTAL-1.
- hSync  out  1  horizontal sync, active low.
- vSync  out  1  vertical sync, active low.
- bright  out  1  high inside the visible window.
- frame_tick  out  1  one-clk pulse on the last pixel of each frame.

Behaviour:
- Reset (async, rst=1):
  - Divider=0; pix_en=0; hCount=0; vCount=0; frame_tick=0; bright=0.
  - hSync=0 and vSync=0, because position (0,0) lies inside both sync pulses.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and high for exactly the clk cycle in which divider==CLK_DIV-1.
  - The first pix_en after reset release therefore occurs CLK_DIV cycles later.
  - CLK_DIV=1: pix_en stays high from the first clk edge after reset.
- Counters advance only on a clk edge where pix_en=1:
  - hCount==H_TOTAL-1 wraps to 0 and increments vCount.
  - vCount==V_TOTAL-1 together with the hCount wrap sends vCount to 0.
  - hCount and vCount never take values outside their ranges.
- hSync, vSync and bright are registered and decoded from the next counter values, so they change on the same edge as hCount/vCount:
  - hSync = (hCount >= H_SYNC).
  - vSync = (vCount >= V_SYNC).
  - bright = H_VIS_START <= hCount < H_VIS_END and V_VIS_START <= vCount < V_VIS_END.
- frame_tick is high for the single clk cycle in which pix_en=1 and (hCount,vCount)=(H_TOTAL-1,V_TOTAL-1). Its period is H_TOTAL*V_TOTAL*CLK_DIV clk.
- Outputs hold their values between pix_en edges.
- Reset asserted mid-line returns everything to the reset values immediately. Release restarts the frame from (0,0) with a full-length sync pulse.
- Latency: no combinational path from any input to any output.

Optional Feature:
- Macro: VGA_SYNC_ALIGN_EN.
- Defined: hSync and vSync pass through one extra clk register stage (reset value 0). This matches the one-cycle ROM read latency of the downstream sprite controllers, so sync edges line up with rgb at the DAC. hCount/vCount/bright/pix_en/frame_tick are unchanged.
- Undefined: hSync/vSync follow the timing above with no extra delay.

Decomposition:
- Package vga_timing_pkg holds:
  - the H_*/V_* constants and CLK_DIV default;
  - COUNT_W=10;
  - derived SCREEN_W=640 and SCREEN_H=480, shared with sprite controllers for placement arithmetic.
- Sub-module vga_pixel_tick holds the divider and pix_en register (parameter CLK_DIV). The counter and decode logic stay in the top.

Test Plan:
- Reset release, CLK_DIV=4: first pix_en at clk 4, then every 4 clk; hCount reads 1 after the first pix_en.
- Line timing: hSync low for exactly 96*4=384 clk per line; bright rises when hCount becomes 144 and falls when it becomes 784 (on a visible line); line period 3200 clk.
- Frame timing: vSync low for 2 lines (6400 clk); bright stays 0 on vCount 0..34 and 515..524; frame_tick period 1,680,000 clk, high for exactly 1 clk.
- Wrap: at (799,524) with pix_en, the next state is (0,0), hSync=0, vSync=0, bright=0, frame_tick=1 during the wrap cycle.
- Mid-frame reset: assert rst at (400,200) → outputs immediately at reset values; after release, counting resumes from (0,0).
- VGA_SYNC_ALIGN_EN defined: hSync falling edge lags the hCount wrap to 0 by exactly 1 clk; bright is unchanged.
